// File: rtl/resp_tx_pkg.sv
// resp_tx_pkg: shared state encoding and frame layout constants for the response transmitter
package resp_tx_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SEND, GAP, WAIT_TX, DONE} state_t;
    localparam logic [7:0] HDR_BYTE   = 8'h55;
    localparam int         FRAME_LEN  = 67;
    localparam logic [6:0] DATA_FIRST = 7'd2;
    localparam logic [6:0] DATA_LAST  = 7'd65;
    localparam logic [6:0] LAST_IDX   = 7'(FRAME_LEN - 1);
endpackage

// File: rtl/resp_tx.sv
// resp_tx: sends a 67-byte response frame (header, status, 16 accumulator words, checksum) to a UART
module resp_tx
    import resp_tx_pkg::*;
#(
    parameter logic [7:0] HDR = HDR_BYTE
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        start,
    input  logic [7:0]  status,
    input  logic [31:0] acc_data,
    output logic [3:0]  sel,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        busy,
    output logic        done
);
    state_t     state;
    logic [6:0] idx;
    logic [7:0] csum;
    logic [7:0] stat;
    logic       is_data;
    logic [6:0] didx;
    logic [7:0] data_byte;
    logic [7:0] cur_byte;

    always_comb begin
        is_data   = idx >= DATA_FIRST && idx <= DATA_LAST;
        didx      = idx - DATA_FIRST;
        data_byte = didx[1:0] == 2'd0 ? acc_data[31:24] :
                    didx[1:0] == 2'd1 ? acc_data[23:16] :
                    didx[1:0] == 2'd2 ? acc_data[15:8]  : acc_data[7:0];
        cur_byte  = idx == 7'd0 ? HDR :
                    idx == 7'd1 ? stat :
                    is_data     ? data_byte : csum;
    end

    // done is still high in the IDLE cycle after DONE, which is how a coincident start gets dropped
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= IDLE;
            idx     <= '0;
            csum    <= '0;
            stat    <= '0;
            sel     <= '0;
            tx_data <= '0;
            tx_send <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tx_send <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: if (start && !done) begin
                    stat  <= status;
                    idx   <= '0;
                    csum  <= '0;
                    busy  <= 1'b1;
                    state <= SETUP;
                end
                SETUP: begin
                    sel   <= is_data ? didx[5:2] : 4'd0;
                    state <= SEND;
                end
                SEND: if (!tx_busy) begin
                    tx_data <= cur_byte;
                    tx_send <= 1'b1;
                    if (idx != 7'd0 && idx != LAST_IDX) csum <= csum + cur_byte;
                    state   <= GAP;
                end
                GAP: state <= WAIT_TX;
                WAIT_TX: if (!tx_busy) begin
                    if (idx < LAST_IDX) begin
                        idx   <= idx + 7'd1;
                        state <= SETUP;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_resp_tx.sv
// tb_resp_tx: table-driven frame checks plus hand-written reset-abort sequence for resp_tx
module tb_resp_tx;
    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  status = '0;
    logic [31:0] acc_data;
    logic [3:0]  sel;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        busy;
    logic        done;

    logic [31:0] mem [16];
    logic [7:0]  cap [80];
    logic [7:0]  exp_b [67];
    int          nb, done_cnt, viol, bcnt, busy_len;
    logic        clr = 1'b1;
    int          ncmp = 0, nerr = 0;

    typedef struct {
        string      name;
        logic [7:0] status;
        int         pattern;
        int         busy_len;
        bit         spam;
        logic [7:0] exp_csum;
    } vec_t;
    vec_t vt [6];

    resp_tx dut (
        .clk(clk), .nRst(nRst), .start(start), .status(status), .acc_data(acc_data),
        .sel(sel), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign acc_data = mem[sel];
    assign tx_busy  = bcnt != 0;

    // UART model and frame capture, sampled mid-cycle
    always @(negedge clk) begin
        if (clr) begin
            nb <= 0; done_cnt <= 0; viol <= 0; bcnt <= 0;
        end else begin
            if (tx_send && tx_busy) viol <= viol + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (tx_send) begin
                if (nb < 80) cap[nb] <= tx_data;
                nb   <= nb + 1;
                bcnt <= busy_len;
            end else if (bcnt != 0) begin
                bcnt <= bcnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        ncmp++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic fill(input int pattern);
        for (int k = 0; k < 16; k++)
            mem[k] = pattern == 0 ? 32'h0 : pattern == 1 ? 32'h01020304 * 32'(k + 1) : 32'hFFFF_FFFF;
    endtask

    task automatic build_expected(input logic [7:0] st);
        logic [7:0] s;
        logic [31:0] w;
        exp_b[0] = 8'h55;
        exp_b[1] = st;
        s = st;
        for (int i = 0; i < 64; i++) begin
            w = mem[i / 4];
            exp_b[2 + i] = w[8 * (3 - i % 4) +: 8];
            s = s + exp_b[2 + i];
        end
        exp_b[66] = s;
    endtask

    task automatic run_frame(input vec_t v);
        bit got;
        fill(v.pattern);
        busy_len = v.busy_len;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        build_expected(v.status);
        status = v.status;
        start = 1'b1;
        tick();
        if (!v.spam) start = 1'b0;
        check({v.name, " busy_after_start"}, 32'(busy), 1);
        got = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            tick();
            if (done) begin
                got = 1'b1;
                tick();
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        check({v.name, " done_seen"}, 32'(got), 1);
        repeat (40) tick();
        check({v.name, " byte_count"}, nb, 67);
        for (int i = 0; i < 67; i++)
            check($sformatf("%s byte[%0d]", v.name, i), 32'(cap[i]), 32'(exp_b[i]));
        check({v.name, " checksum_hand"}, 32'(cap[66]), 32'(v.exp_csum));
        check({v.name, " done_count"}, done_cnt, 1);
        check({v.name, " send_while_busy"}, viol, 0);
        check({v.name, " busy_idle"}, 32'(busy), 0);
    endtask

    initial begin
        vt[0] = '{"t1_zero",   8'hAA, 0, 2,  1'b0, 8'hAA};
        vt[1] = '{"t2_ramp",   8'h00, 1, 1,  1'b0, 8'h50};
        vt[2] = '{"t3_slowtx", 8'h10, 1, 10, 1'b0, 8'h60};
        vt[3] = '{"t4_spam",   8'h5A, 0, 3,  1'b1, 8'h5A};
        vt[4] = '{"t6_ones",   8'hFF, 2, 0,  1'b0, 8'hBF};
        vt[5] = '{"t5_after",  8'h21, 1, 2,  1'b0, 8'h71};
        busy_len = 2;
        fill(0);
        repeat (3) tick();
        check("rst sel", 32'(sel), 0);
        check("rst tx_data", 32'(tx_data), 0);
        check("rst tx_send", 32'(tx_send), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        nRst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) run_frame(vt[i]);

        // reset in the middle of a frame
        fill(1);
        busy_len = 2;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        status = 8'h33;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 3000 && nb < 21; t++) tick();
        check("t5 reached_byte20", 32'(nb >= 21), 1);
        nRst = 1'b0;
        #1;
        check("t5 sel", 32'(sel), 0);
        check("t5 tx_data", 32'(tx_data), 0);
        check("t5 tx_send", 32'(tx_send), 0);
        check("t5 busy", 32'(busy), 0);
        check("t5 done", 32'(done), 0);
        repeat (3) tick();
        nRst = 1'b1;
        begin
            int nb0;
            nb0 = nb;
            repeat (100) tick();
            check("t5 no_more_sends", nb, nb0);
        end
        check("t5 no_done", done_cnt, 0);
        check("t5 busy_after", 32'(busy), 0);
        run_frame(vt[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
